clock_disp_scan: RTL and testbench

- Downstream display stage of the digital clock.
- Consumes the 8421-BCD hour (00-23), minute and second counts.
- Drives a 6-digit, time-multiplexed common-anode 7-segment display.
- Provides per-digit blinking for time-set mode, optional hour-tens leading-zero blanking, inter-digit dead time (anti-ghosting), and frame-coherent input latching so a carry never tears the display.

---
 rtl/clock_pkg.sv | 37 +++
 rtl/seg7_decode.sv | 28 ++
 rtl/clock_disp_scan.sv | 166 ++++++++++++++++
 tb/tb_clock_disp_scan.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared display constants for the digital clock: 7-segment glyphs
// (bit 0 = a ... bit 6 = g, active-high), digit positions, and the
// helpers that turn clock/scan/blink rates into cycle counts.
package clock_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Digit positions, right to left on the display
    localparam logic [2:0] DIG_SEC_ONES = 3'd0;
    localparam logic [2:0] DIG_SEC_TENS = 3'd1;
    localparam logic [2:0] DIG_MIN_ONES = 3'd2;
    localparam logic [2:0] DIG_MIN_TENS = 3'd3;
    localparam logic [2:0] DIG_HR_ONES  = 3'd4;
    localparam logic [2:0] DIG_HR_TENS  = 3'd5;

    // Cycles spent on each digit before moving to the next one
    function automatic int slot_cycles(input int clk_hz, input int scan_hz);
        return clk_hz / scan_hz;
    endfunction

    // Cycles between blink phase toggles (half a blink period)
    function automatic int blink_half_cycles(input int clk_hz, input int blink_hz);
        return clk_hz / (2 * blink_hz);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder, active-high segments a..g.
// Non-decimal codes show a dash so a corrupted count is visible.
module seg7_decode
    import clock_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Glyph lookup
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/clock_disp_scan.sv
// Six-digit multiplexed 7-segment scanner for the clock display.
// The time is latched once per frame so a carry rippling through
// hour/min/sec mid-scan never shows a torn value. Each digit slot opens
// with a few dark cycles so the digit switch cannot ghost. Logic is
// active-high internally; polarity is applied only at the output flops.
module clock_disp_scan
    import clock_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int SCAN_HZ     = 6000,
    parameter int BLINK_HZ    = 2,
    parameter int DEAD_CYC    = 2,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit DIG_ACT_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] hour,
    input  logic [7:0] min,
    input  logic [7:0] sec,
    input  logic [5:0] blink_mask,
    input  logic       blank_lead,
    output logic [7:0] seg,
    output logic [5:0] dig,
    output logic       frame
);

    localparam int SLOT       = slot_cycles(CLK_HZ, SCAN_HZ);
    localparam int BLINK_HALF = blink_half_cycles(CLK_HZ, BLINK_HZ);
    localparam int SW         = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT - 1);
    localparam logic [SW-1:0] DEAD_LIMIT = SW'(DEAD_CYC);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    // Idle levels: everything dark in the configured polarity
    localparam logic [7:0] SEG_IDLE = {8{SEG_ACT_LOW}};
    localparam logic [5:0] DIG_IDLE = {6{DIG_ACT_LOW}};

    // Scan state
    logic [SW-1:0] slot_cnt_q, slot_cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [23:0]   time_q, time_d;
    logic          frame_q, frame_d;

    // Blink state
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;

    // Output registers (already polarity-adjusted)
    logic [7:0]    seg_q, seg_d;
    logic [5:0]    dig_q, dig_d;

    // Display datapath intermediates
    logic          slot_wrap;
    logic          frame_wrap;
    logic [3:0]    nibble;
    logic [6:0]    glyph;
    logic          dp_on;
    logic          blank;
    logic [7:0]    seg_act;
    logic [5:0]    dig_act;

    seg7_decode u_decode (
        .bcd (nibble),
        .seg (glyph)
    );

    // Slot counter, scan index and frame-coherent time latch
    always_comb begin
        slot_wrap  = (slot_cnt_q == SLOT_LAST);
        frame_wrap = slot_wrap && (idx_q == DIG_HR_TENS);
        slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (slot_wrap) begin
            idx_d = frame_wrap ? 3'd0 : idx_q + 3'd1;
        end
        time_d  = frame_wrap ? {hour, min, sec} : time_q;
        frame_d = frame_wrap;
    end

    // Free-running blink phase, independent of the scan
    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_ph_d  = blink_ph_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end
    end

    // Digit selection, blanking and polarity for the next output cycle
    always_comb begin
        nibble = 4'd0;
        case (idx_q)
            DIG_SEC_ONES: nibble = time_q[3:0];
            DIG_SEC_TENS: nibble = time_q[7:4];
            DIG_MIN_ONES: nibble = time_q[11:8];
            DIG_MIN_TENS: nibble = time_q[15:12];
            DIG_HR_ONES:  nibble = time_q[19:16];
            DIG_HR_TENS:  nibble = time_q[23:20];
            default:      nibble = 4'd0;
        endcase

        // Separators sit after the minute and hour ones digits
        dp_on = (idx_q == DIG_MIN_ONES) || (idx_q == DIG_HR_ONES);

        blank = (slot_cnt_q < DEAD_LIMIT)
             || (blink_ph_q && blink_mask[idx_q])
             || ((idx_q == DIG_HR_TENS) && blank_lead && (time_q[23:20] == 4'd0))
             || (idx_q > DIG_HR_TENS);

        seg_act = {dp_on, glyph};
        dig_act = 6'b000001 << idx_q;
        if (blank) begin
            seg_act = {1'b0, SEG_OFF};
            dig_act = 6'b000000;
        end

        seg_d = seg_act ^ SEG_IDLE;
        dig_d = dig_act ^ DIG_IDLE;
    end

    // Scan and latch registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q <= '0;
            idx_q      <= 3'd0;
            time_q     <= 24'h000000;
            frame_q    <= 1'b0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
            time_q     <= time_d;
            frame_q    <= frame_d;
        end
    end

    // Blink registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    // Output registers; reset forces the display dark immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_IDLE;
            dig_q <= DIG_IDLE;
        end else begin
            seg_q <= seg_d;
            dig_q <= dig_d;
        end
    end

    assign seg   = seg_q;
    assign dig   = dig_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_clock_disp_scan.sv
// Bench for clock_disp_scan at a scaled-down clock: SLOT = 12 cycles,
// blink toggles every 60 cycles, 2 dead cycles, active-low outputs.
module tb_clock_disp_scan;

    localparam int SLOT_N = 12;
    localparam int HALF_N = 60;
    localparam int DEAD_N = 2;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] hour = 8'h00;
    logic [7:0] min = 8'h00;
    logic [7:0] sec = 8'h00;
    logic [5:0] blink_mask = 6'h00;
    logic       blank_lead = 1'b0;
    logic [7:0] seg;
    logic [5:0] dig;
    logic       frame;

    always #5 clk = ~clk;

    clock_disp_scan #(
        .CLK_HZ      (1200),
        .SCAN_HZ     (100),
        .BLINK_HZ    (10),
        .DEAD_CYC    (2),
        .SEG_ACT_LOW (1'b1),
        .DIG_ACT_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hour       (hour),
        .min        (min),
        .sec        (sec),
        .blink_mask (blink_mask),
        .blank_lead (blank_lead),
        .seg        (seg),
        .dig        (dig),
        .frame      (frame)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected {frame, seg, dig} per cycle
    logic [14:0] exp_q[$];
    int          m_slot;
    int          m_idx;
    int          m_bc;
    logic        m_ph;
    logic [23:0] m_time;

    function automatic logic [6:0] glyph_of(input logic [3:0] n);
        logic [6:0] t [0:9];
        t[0] = 7'h3F; t[1] = 7'h06; t[2] = 7'h5B; t[3] = 7'h4F; t[4] = 7'h66;
        t[5] = 7'h6D; t[6] = 7'h7D; t[7] = 7'h07; t[8] = 7'h7F; t[9] = 7'h6F;
        if (n > 4'd9) return 7'h40;
        return t[n];
    endfunction

    function automatic logic [14:0] model_out();
        logic [3:0] nib;
        logic       blank;
        logic [7:0] s;
        logic [5:0] d;
        logic       fr;
        nib   = m_time[m_idx*4 +: 4];
        blank = (m_slot < DEAD_N) || (m_ph && blink_mask[m_idx])
             || (m_idx == 5 && blank_lead && m_time[23:20] == 4'd0);
        s = {(m_idx == 2 || m_idx == 4), glyph_of(nib)};
        d = 6'b000001 << m_idx;
        if (blank) begin
            s = 8'h00;
            d = 6'h00;
        end
        fr = (m_slot == SLOT_N - 1) && (m_idx == 5);
        return {fr, ~s, ~d};
    endfunction

    task automatic model_reset();
        m_slot = 0; m_idx = 0; m_bc = 0; m_ph = 1'b0; m_time = 24'h0;
        exp_q.delete();
    endtask

    task automatic model_step();
        if (m_slot == SLOT_N - 1) begin
            m_slot = 0;
            if (m_idx == 5) begin
                m_idx  = 0;
                m_time = {hour, min, sec};
            end else begin
                m_idx++;
            end
        end else begin
            m_slot++;
        end
        if (m_bc == HALF_N - 1) begin
            m_bc = 0;
            m_ph = ~m_ph;
        end else begin
            m_bc++;
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock: predict, advance, then compare at the falling edge
    task automatic tick();
        logic [14:0] e;
        exp_q.push_back(model_out());
        model_step();
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check_eq("scan", {17'd0, frame, seg, dig}, {17'd0, e});
    endtask

    task automatic wait_frame();
        bit found = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (frame) begin
                found = 1;
                break;
            end
        end
        check_eq("wait_frame", found, 1);
    endtask

    task automatic wait_digit(input int i, input string tag, input logic [7:0] exp_seg);
        logic [5:0] want;
        bit found = 0;
        want = 6'b000001 << i;
        want = ~want;
        for (int k = 0; k < 200; k++) begin
            if (dig == want) begin
                found = 1;
                break;
            end
            tick();
        end
        check_eq({tag, "_found"}, found, 1);
        check_eq(tag, seg, exp_seg);
    endtask

    task automatic hold_reset(input int cycles);
        rst_n = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            check_eq("rst_seg", seg, 8'hFF);
            check_eq("rst_dig", dig, 6'h3F);
            check_eq("rst_frame", frame, 0);
        end
        model_reset();
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    int act_cnt [6];
    bit dark_hr_seen;

    initial begin
        // 1: reset release, first frame shows 23:59:58
        hour = 8'h23; min = 8'h59; sec = 8'h58;
        @(negedge clk);
        hold_reset(3);
        wait_digit(0, "pre_latch_d0", 8'hC0);
        wait_frame();
        wait_digit(0, "d0_eight", 8'h80);
        wait_digit(2, "d2_nine_dp", 8'h10);
        wait_digit(4, "d4_three_dp", 8'h30);
        wait_digit(5, "d5_two", 8'hA4);

        // 2: steady scan, 10 lit cycles per digit, one-hot, 72-cycle frame
        wait_frame();
        for (int i = 0; i < 6; i++) act_cnt[i] = 0;
        for (int k = 0; k < 72; k++) begin
            tick();
            check_eq("onehot", ($countones(~dig) <= 1), 1);
            for (int i = 0; i < 6; i++) begin
                if (dig == ~(6'b000001 << i)) act_cnt[i]++;
            end
            if (k < 71) check_eq("no_early_frame", frame, 0);
        end
        check_eq("frame_period", frame, 1);
        for (int i = 0; i < 6; i++) check_eq("lit_cycles", act_cnt[i], 10);

        // 3: seconds change mid-frame shows only after the next frame
        wait_digit(2, "d2_before_change", 8'h10);
        sec = 8'h59;
        wait_frame();
        wait_digit(0, "d0_nine", 8'h90);

        // 4: hour digits blink, others steady
        blink_mask = 6'b110000;
        dark_hr_seen = 0;
        for (int k = 0; k < 240; k++) begin
            if (m_idx >= 4 && m_slot >= DEAD_N && m_ph) begin
                tick();
                if (dig == 6'h3F) dark_hr_seen = 1;
            end else begin
                tick();
            end
        end
        check_eq("blink_dark", dark_hr_seen, 1);
        blink_mask = 6'b000000;

        // 5: leading-zero blanking on hour tens
        hour = 8'h07; blank_lead = 1'b1;
        wait_frame();
        wait_frame();
        act_cnt[5] = 0;
        for (int k = 0; k < 72; k++) begin
            tick();
            if (dig == 6'b011111) act_cnt[5]++;
        end
        check_eq("d5_blanked", act_cnt[5], 0);
        wait_digit(4, "d4_seven_dp", 8'h78);
        blank_lead = 1'b0;
        wait_digit(5, "d5_zero", 8'hC0);

        // 6: invalid nibble shows dash, then asynchronous reset mid-slot
        hour = 8'h0C;
        wait_frame();
        wait_digit(4, "d4_dash_dp", 8'h3F);
        check_eq("pre_rst_dig", dig, 6'b101111);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_seg", seg, 8'hFF);
        check_eq("async_dig", dig, 6'h3F);
        check_eq("async_frame", frame, 0);
        @(negedge clk);
        hold_reset(2);
        wait_digit(0, "restart_d0_zero", 8'hC0);
        check_eq("restart_idx", m_idx, 0);
        for (int k = 0; k < 30; k++) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
